speed_test_sequencer: RTL and testbench

AXI4-Lite master sitting directly upstream of the speed-test controller register slave. It accepts one test command (duration plus four port configs), programs the controller, starts the test and polls busy until completion. It then reads back the 16 result words and the elapsed-ms word and streams them out. Host logic can run a full test without a CPU.

---
 rtl/speed_test_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_speed_test_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_test_sequencer.sv
// AXI4-Lite master that programs the speed-test controller, runs one test to completion
// and streams the 16 result words plus the elapsed-ms word out on a valid/ready port.
`timescale 1ns/1ps
module speed_test_sequencer #(
    parameter int          ADDR_WIDTH     = 9,
    parameter int          POLL_INTERVAL  = 1024,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250000000
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [12:0]           cmd_duration,
    input  logic [1023:0]         cmd_config,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [2:0]            m_awprot,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [2:0]            m_arprot,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [31:0]           res_data,
    output logic [4:0]            res_index,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_last,
    output logic                  error,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE_RD, S_PRE_WAIT, S_WR_DUR, S_WR_CFG, S_WR_START,
        S_POLL_WAIT, S_POLL_RD, S_RD_RES, S_RD_MS, S_RES_DRAIN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [12:0]             r_duration;
    logic [1023:0]           r_config;
    logic [4:0]              r_idx;
    logic [31:0]             r_wait_cnt;
    logic [31:0]             r_poll_cnt;
    logic                    r_op_busy, r_op_wr;
    logic                    r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready;
    logic                    r_arvalid, r_rready;
    logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
    logic [31:0]             r_wdata;
    logic [31:0]             r_res_data;
    logic [4:0]              r_res_index;
    logic                    r_res_valid;
    logic                    r_error, r_busy, r_cmd_ready;

    logic [31:0]             w_cfg_word [32];
    logic                    w_cmd_accept;
    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_wr_done, w_rd_done;
    logic                    w_aw_fin, w_w_fin;
    logic                    w_launch_wr, w_launch_rd;
    logic                    w_wait_done, w_timeout, w_res_hs;
    logic [ADDR_WIDTH-1:0]   w_wr_addr, w_rd_addr;
    logic [31:0]             w_wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cfg
            assign w_cfg_word[gi] = r_config[32*gi +: 32];
        end
    endgenerate

    assign w_cmd_accept = cmd_valid & r_cmd_ready & (r_state == S_IDLE);
    assign w_aw_hs      = r_awvalid & m_awready;
    assign w_w_hs       = r_wvalid & m_wready;
    assign w_ar_hs      = r_arvalid & m_arready;
    assign w_wr_done    = r_bready & m_bvalid;
    assign w_rd_done    = r_rready & m_rvalid;
    assign w_aw_fin     = r_aw_done | w_aw_hs;
    assign w_w_fin      = r_w_done | w_w_hs;
    assign w_res_hs     = r_res_valid & res_ready;
    assign w_wait_done  = (r_wait_cnt == 32'(POLL_INTERVAL - 1));
    assign w_timeout    = (TIMEOUT_CYCLES != 32'd0) && (r_poll_cnt >= TIMEOUT_CYCLES);

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_launch_wr  = 1'b0;
        w_launch_rd  = 1'b0;
        w_wr_addr    = '0;
        w_wr_data    = '0;
        w_rd_addr    = '0;
        case (r_state)
            S_IDLE:      if (w_cmd_accept) w_state_next = S_PRE_RD;
            S_PRE_RD: begin
                w_launch_rd = ~r_op_busy;
                if (w_rd_done) w_state_next = m_rdata[0] ? S_PRE_WAIT : S_WR_DUR;
            end
            S_PRE_WAIT:  if (w_wait_done) w_state_next = S_PRE_RD;
            S_WR_DUR: begin
                w_launch_wr = ~r_op_busy;
                w_wr_addr   = ADDR_WIDTH'(12'h008);
                w_wr_data   = {19'b0, r_duration};
                if (w_wr_done) w_state_next = S_WR_CFG;
            end
            S_WR_CFG: begin
                w_launch_wr = ~r_op_busy;
                w_wr_addr   = ADDR_WIDTH'(12'h100 + {5'b0, r_idx, 2'b00});
                w_wr_data   = w_cfg_word[r_idx];
                if (w_wr_done && r_idx == 5'd31) w_state_next = S_WR_START;
            end
            S_WR_START: begin
                w_launch_wr = ~r_op_busy;
                w_wr_addr   = ADDR_WIDTH'(12'h004);
                w_wr_data   = 32'h0000_00FF;
                if (w_wr_done) w_state_next = S_POLL_WAIT;
            end
            // Timeout is only honoured between polls so no read is ever abandoned.
            S_POLL_WAIT: begin
                if (w_timeout)        w_state_next = S_RD_RES;
                else if (w_wait_done) w_state_next = S_POLL_RD;
            end
            S_POLL_RD: begin
                w_launch_rd = ~r_op_busy;
                if (w_rd_done) w_state_next = m_rdata[0] ? S_POLL_WAIT : S_RD_RES;
            end
            S_RD_RES: begin
                w_launch_rd = ~r_op_busy & ~r_res_valid;
                w_rd_addr   = ADDR_WIDTH'(12'h180 + {5'b0, r_idx, 2'b00});
                if (w_rd_done && r_idx == 5'd15) w_state_next = S_RD_MS;
            end
            S_RD_MS: begin
                w_launch_rd = ~r_op_busy & ~r_res_valid;
                w_rd_addr   = ADDR_WIDTH'(12'h008);
                if (w_rd_done) w_state_next = S_RES_DRAIN;
            end
            S_RES_DRAIN: if (w_res_hs) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            r_duration  <= '0;
            r_config    <= '0;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_poll_cnt  <= '0;
            r_op_busy   <= 1'b0;
            r_op_wr     <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_res_data  <= '0;
            r_res_index <= '0;
            r_res_valid <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_next == S_IDLE);
            r_busy      <= (w_state_next != S_IDLE);

            if (w_cmd_accept) begin
                r_duration <= (cmd_duration == 13'd0) ? 13'd1 : cmd_duration;
                r_config   <= cmd_config;
            end

            // AW and W launch together and retire independently; B is taken once both are in.
            if (w_launch_wr) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_awaddr  <= w_wr_addr;
                r_wdata   <= w_wr_data;
                r_op_busy <= 1'b1;
                r_op_wr   <= 1'b1;
            end else if (w_wr_done) begin
                r_bready  <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_op_busy <= 1'b0;
                r_op_wr   <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end
                if (r_op_wr && w_aw_fin && w_w_fin) r_bready <= 1'b1;
            end

            if (w_launch_rd) begin
                r_arvalid <= 1'b1;
                r_araddr  <= w_rd_addr;
                r_op_busy <= 1'b1;
            end else if (w_ar_hs) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
            end else if (w_rd_done) begin
                r_rready  <= 1'b0;
                r_op_busy <= 1'b0;
            end

            if (r_state == S_PRE_WAIT || r_state == S_POLL_WAIT) r_wait_cnt <= r_wait_cnt + 32'd1;
            else                                                 r_wait_cnt <= '0;

            if (r_state == S_POLL_WAIT || r_state == S_POLL_RD) r_poll_cnt <= r_poll_cnt + 32'd1;
            else                                                r_poll_cnt <= '0;

            if ((r_state == S_WR_CFG && w_wr_done) || (r_state == S_RD_RES && w_rd_done))
                r_idx <= r_idx + 5'd1;
            else if (r_state != S_WR_CFG && r_state != S_RD_RES)
                r_idx <= '0;

            if (w_rd_done && r_state == S_RD_RES) begin
                r_res_data  <= m_rdata;
                r_res_index <= r_idx;
                r_res_valid <= 1'b1;
            end else if (w_rd_done && r_state == S_RD_MS) begin
                r_res_data  <= {16'b0, m_rdata[15:0]};
                r_res_index <= 5'd16;
                r_res_valid <= 1'b1;
            end else if (w_res_hs) begin
                r_res_valid <= 1'b0;
            end

            if (w_cmd_accept)
                r_error <= 1'b0;
            else if ((w_wr_done && m_bresp != 2'b00) || (w_rd_done && m_rresp != 2'b00) ||
                     (r_state == S_POLL_WAIT && w_timeout))
                r_error <= 1'b1;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign error     = r_error;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_awprot  = 3'b000;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = 4'hF;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_arprot  = 3'b000;
    assign m_rready  = r_rready;
    assign res_data  = r_res_data;
    assign res_index = r_res_index;
    assign res_valid = r_res_valid;
    assign res_last  = (r_res_index == 5'd16);

endmodule

// File: tb/tb_speed_test_sequencer.sv
// Scoreboard bench for speed_test_sequencer: AXI-Lite slave model, expected write and
// result queues filled at command issue, monitors popping and comparing on each handshake.
`timescale 1ns/1ps
module tb_speed_test_sequencer;
    localparam int          AW = 9;
    localparam int          PI = 16;
    localparam logic [31:0] TO = 32'd5000;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0, cmd_ready;
    logic [12:0]     cmd_duration = '0;
    logic [1023:0]   cmd_config = '0;
    logic [AW-1:0]   m_awaddr, m_araddr;
    logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic            m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic [2:0]      m_awprot, m_arprot;
    logic [31:0]     m_wdata;
    logic [3:0]      m_wstrb;
    logic [1:0]      m_bresp = '0, m_rresp = '0;
    logic            m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [31:0]     m_rdata = '0;
    logic [31:0]     res_data;
    logic [4:0]      res_index;
    logic            res_valid, res_last, error, busy;
    logic            res_ready = 1'b0;

    speed_test_sequencer #(.ADDR_WIDTH(AW), .POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
        .S_AXI_ACLK(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_duration(cmd_duration), .cmd_config(cmd_config),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .res_data(res_data), .res_index(res_index), .res_valid(res_valid), .res_ready(res_ready),
        .res_last(res_last), .error(error), .busy(busy)
    );

    typedef struct { logic [8:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [4:0] idx; logic [31:0] data; logic last; } res_t;
    wr_t  exp_wr[$];
    res_t exp_res[$];

    int n_vec = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave / sink configuration for the current command.
    int          mode = 0;            // 0 = zero-wait, 1 = random ready, 2 = W leads AW by 4
    int          busy_left = 0, pre_busy_left = 0;
    bit          stuck = 0, started = 0, stall_en = 0, sink_rand = 0;
    int          stall_cnt = 0;
    logic [8:0]  bad_wr = 9'h1FF, bad_rd = 9'h1FF;
    logic [31:0] res_mem [16];
    logic [31:0] ms_word = '0;
    int          wr_cnt = 0, res_cnt = 0, start_cyc = 0, first_res_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_read(input logic [8:0] a, output logic [31:0] d);
        logic [31:0] rnd;
        bit          b;
        rnd = $urandom;
        b   = 0;
        if (a == 9'h000) begin
            if (!started) begin
                b = (pre_busy_left > 0);
                if (b) pre_busy_left--;
            end else if (stuck) b = 1;
            else begin
                b = (busy_left > 0);
                if (b) busy_left--;
            end
            d = {rnd[31:1], b};
        end else if (a == 9'h008) d = ms_word;
        else if (a >= 9'h180 && a <= 9'h1BC) d = res_mem[int'((a - 9'h180) >> 2)];
        else d = rnd;
    endtask

    task automatic log_write(input logic [8:0] a, input logic [31:0] d);
        wr_t e;
        wr_cnt++;
        if (a == 9'h004 && d == 32'hFF) begin
            started   = 1;
            start_cyc = cyc;
        end
        if (exp_wr.size() == 0) chk("wr_unexpected", {23'b0, a, d}, 64'h0);
        else begin
            e = exp_wr.pop_front();
            chk("wr_addr_data", {23'b0, a, d}, {23'b0, e.addr, e.data});
        end
    endtask

    // AXI-Lite slave: decides readies on the falling edge, so a handshake seen here completes
    // at the following rising edge.
    initial begin
        bit aw_got = 0, w_got = 0, ar_got = 0, b_hs = 0, r_hs = 0;
        int w_age = 0;
        logic [8:0]  s_awaddr = '0, s_araddr = '0;
        logic [31:0] s_wdata = '0, rd;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                m_bvalid = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_arready = 0;
            end else begin
                if (b_hs) m_bvalid = 0;
                if (r_hs) m_rvalid = 0;
                if (aw_got && w_got && !m_bvalid) begin
                    m_bvalid = 1;
                    m_bresp  = (s_awaddr == bad_wr) ? 2'b10 : 2'b00;
                    log_write(s_awaddr, s_wdata);
                    aw_got = 0; w_got = 0;
                end
                if (ar_got && !m_rvalid) begin
                    slave_read(s_araddr, rd);
                    m_rvalid = 1;
                    m_rdata  = rd;
                    m_rresp  = (s_araddr == bad_rd) ? 2'b10 : 2'b00;
                    ar_got   = 0;
                end
                case (mode)
                    1: begin
                        m_awready = !aw_got && ($urandom_range(0, 2) != 0);
                        m_wready  = !w_got && ($urandom_range(0, 2) != 0);
                        m_arready = !ar_got && ($urandom_range(0, 2) != 0);
                    end
                    2: begin
                        m_wready  = !w_got;
                        m_awready = !aw_got && w_got && (w_age >= 4);
                        m_arready = !ar_got;
                    end
                    default: begin
                        m_awready = !aw_got; m_wready = !w_got; m_arready = !ar_got;
                    end
                endcase
                if (m_awvalid && m_awready) begin
                    aw_got = 1; s_awaddr = m_awaddr;
                end
                if (m_wvalid && m_wready) begin
                    w_got = 1; s_wdata = m_wdata; w_age = 0;
                    chk("wstrb", {60'b0, m_wstrb}, 64'hF);
                end else if (w_got && !aw_got) w_age++;
                if (m_arvalid && m_arready) begin
                    ar_got = 1; s_araddr = m_araddr;
                    if (m_araddr == 9'h180 && first_res_cyc < 0) first_res_cyc = cyc;
                end
                b_hs = m_bvalid && m_bready;
                r_hs = m_rvalid && m_rready;
            end
        end
    end

    // Result sink and monitor.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst) res_ready = 0;
            else begin
                if (stall_en && res_valid && res_index == 5'd3 && stall_cnt < 20) begin
                    res_ready = 0;
                    stall_cnt++;
                    chk("stall_no_ar", {63'b0, m_arvalid}, 64'h0);
                    chk("stall_data", {32'b0, res_data}, {32'b0, res_mem[3]});
                end else res_ready = sink_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (res_valid && res_ready) begin
                    res_cnt++;
                    if (exp_res.size() == 0) chk("res_unexpected", {26'b0, res_index, res_data, res_last}, 64'h0);
                    else begin
                        e = exp_res.pop_front();
                        chk("res_idx_data_last", {26'b0, res_index, res_data, res_last},
                            {26'b0, e.idx, e.data, e.last});
                    end
                end
            end
        end
    end

    logic [1023:0] cfg_v;

    // Reference: write order and result stream follow directly from the command contents.
    task automatic setup(input logic [12:0] dur, input int md, input int bp, input int pb, input bit stk,
                         input bit stl, input logic [8:0] bw, input logic [8:0] br);
        wr_t  w;
        res_t r;
        mode = md; busy_left = bp; pre_busy_left = pb; stuck = stk; started = 0;
        stall_en = stl; stall_cnt = 0; bad_wr = bw; bad_rd = br;
        wr_cnt = 0; res_cnt = 0; first_res_cyc = -1;
        for (int i = 0; i < 16; i++) res_mem[i] = $urandom;
        ms_word = $urandom;
        w.addr = 9'h008; w.data = {19'b0, (dur == 0) ? 13'd1 : dur}; exp_wr.push_back(w);
        for (int k = 0; k < 32; k++) begin
            w.addr = 9'(9'h100 + 4 * k); w.data = cfg_v[32*k +: 32]; exp_wr.push_back(w);
        end
        w.addr = 9'h004; w.data = 32'hFF; exp_wr.push_back(w);
        for (int i = 0; i < 16; i++) begin
            r.idx = 5'(i); r.data = res_mem[i]; r.last = 0; exp_res.push_back(r);
        end
        r.idx = 5'd16; r.data = {16'b0, ms_word[15:0]}; r.last = 1; exp_res.push_back(r);
    endtask

    task automatic issue(input logic [12:0] dur);
        int g = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_duration = dur; cmd_config = cfg_v;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        chk("cmd_accepted", {63'b0, cmd_ready}, 64'h1);
        @(negedge clk);
        cmd_valid = 0; cmd_duration = 13'($urandom); cmd_config = '1;
        chk("accept_ready_busy_err", {61'b0, cmd_ready, busy, error}, 64'b010);
    endtask

    task automatic run_cmd(input logic [12:0] dur, input int md, input int bp, input int pb, input bit stk,
                           input bit stl, input logic [8:0] bw, input logic [8:0] br);
        int  g = 0;
        bit  exp_err;
        setup(dur, md, bp, pb, stk, stl, bw, br);
        exp_err = (bw != 9'h1FF) || (br != 9'h1FF) || stk;
        issue(dur);
        while (!(res_cnt == 17 && !busy) && g < 20000) begin @(negedge clk); g++; end
        chk("done_in_budget", {63'b0, (g < 20000)}, 64'h1);
        chk("error_flag", {63'b0, error}, {63'b0, exp_err});
        chk("write_count", 64'(wr_cnt), 64'd34);
        chk("queues_drained", 64'(exp_wr.size() + exp_res.size()), 64'd0);
        chk("cmd_ready_idle", {63'b0, cmd_ready}, 64'h1);
        if (stk) chk("timeout_span_ok", {63'b0, (first_res_cyc - start_cyc >= 4990) &&
                                              (first_res_cyc - start_cyc <= 5100)}, 64'h1);
        $display("cmd dur=%0d mode=%0d polls=%0d stuck=%0b error=%0b cycles=%0d", dur, md, bp, stk, error, g);
    endtask

    initial begin
        int g;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {50'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                              res_valid, error, busy, cmd_ready, m_awprot, m_arprot}, 64'h0);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {56'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                               res_valid, error, busy}, 64'h0);
        end
        chk("cmd_ready_after_reset", {63'b0, cmd_ready}, 64'h1);

        for (int k = 0; k < 32; k++) cfg_v[32*k +: 32] = 32'hA000_0000 + k;
        run_cmd(13'd5, 0, 3, 0, 0, 0, 9'h1FF, 9'h1FF);

        for (int k = 0; k < 32; k++) cfg_v[32*k +: 32] = $urandom;
        run_cmd(13'($urandom), 2, 2, 0, 0, 0, 9'h1FF, 9'h1FF);
        run_cmd(13'd100, 0, 1, 0, 0, 1, 9'h1FF, 9'h1FF);
        run_cmd(13'd7, 0, 1, 0, 0, 0, 9'h008, 9'h1FF);
        run_cmd(13'd0, 0, 0, 2, 0, 0, 9'h1FF, 9'h1FF);

        sink_rand = 1;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 32; k++) cfg_v[32*k +: 32] = $urandom;
            run_cmd(13'($urandom), 1, $urandom_range(0, 4), $urandom_range(0, 2), 0, 0, 9'h1FF,
                    (t == 2) ? 9'(9'h180 + 4 * $urandom_range(0, 15)) : 9'h1FF);
        end
        sink_rand = 0;

        run_cmd(13'd9, 0, 0, 0, 1, 0, 9'h1FF, 9'h1FF);

        // Reset in the middle of the configuration writes.
        for (int k = 0; k < 32; k++) cfg_v[32*k +: 32] = $urandom;
        setup(13'd3, 1, 0, 0, 0, 0, 9'h1FF, 9'h1FF);
        issue(13'd3);
        g = 0;
        while (wr_cnt < 10 && g < 2000) begin @(negedge clk); g++; end
        chk("reached_wr_cfg", {63'b0, (wr_cnt >= 10)}, 64'h1);
        rst = 1;
        exp_wr.delete();
        exp_res.delete();
        @(negedge clk);
        chk("mid_reset_quiet", {55'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                                res_valid, error, busy, cmd_ready}, 64'h0);
        rst = 0;
        @(negedge clk);
        chk("post_reset_ready", {62'b0, cmd_ready, busy}, 64'b10);

        for (int k = 0; k < 32; k++) cfg_v[32*k +: 32] = $urandom;
        run_cmd(13'd42, 1, 2, 1, 0, 0, 9'h1FF, 9'h1FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
